// File: rtl/pc_gen.sv
// pc_gen: program counter generator with boot/run/hold/halt sequencing,
// prioritised redirects, a one-deep pending redirect slot and misalignment trap.
//
// state  | meaning
// BOOT   | first cycle after reset, pc = RESET_VECTOR, not yet a valid fetch
// RUN    | normal fetch, pc advances or redirects when advance is high
// HOLD   | a redirect is parked in the pending slot waiting for advance
// HALTED | pc frozen, only a trap request restarts fetch
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned     STEP         = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Enable,
  input  logic            Stall,
  input  logic            FetchReady,
  input  logic            BranchTaken,
  input  logic [XLEN-1:0] BranchOffset,
  input  logic            JumpAbs,
  input  logic [XLEN-1:0] JumpTarget,
  input  logic            TrapReq,
  input  logic            Halt,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            pending,
  output logic            misaligned,
  output logic [XLEN-1:0] misaligned_addr
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  // STEP is expected to be a power of two, so alignment is a low-bit mask test
  localparam logic [XLEN-1:0] STEP_W     = XLEN'(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

  state_t          state, state_n;
  logic [XLEN-1:0] pc_n;
  logic [XLEN-1:0] pend_target, pend_target_n;
  logic            misaligned_n;
  logic [XLEN-1:0] misaligned_addr_n;

  logic            advance;
  logic            redirect;
  logic            halt_req;
  logic [XLEN-1:0] raw_target;
  logic            raw_misaligned;
  logic [XLEN-1:0] resolved_target;

  assign advance  = Enable && !Stall && FetchReady;
  assign redirect = TrapReq || JumpAbs || BranchTaken;
  assign halt_req = Halt && !TrapReq;

  // Redirect target by priority; a misaligned non-trap target becomes a trap
  always_comb begin
    if (TrapReq)
      raw_target = TRAP_VECTOR;
    else if (JumpAbs)
      raw_target = JumpTarget & ~XLEN'(1);
    else
      raw_target = pc + BranchOffset;
    raw_misaligned  = redirect && !TrapReq && ((raw_target & ALIGN_MASK) != '0);
    resolved_target = raw_misaligned ? TRAP_VECTOR : raw_target;
  end

  // State, pc and status registers, asynchronously reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state           <= BOOT;
      pc              <= RESET_VECTOR;
      pend_target     <= '0;
      misaligned      <= 1'b0;
      misaligned_addr <= '0;
    end else begin
      state           <= state_n;
      pc              <= pc_n;
      pend_target     <= pend_target_n;
      misaligned      <= misaligned_n;
      misaligned_addr <= misaligned_addr_n;
    end
  end

  // Next-state, next-pc and misalignment event decode
  always_comb begin
    state_n           = state;
    pc_n              = pc;
    pend_target_n     = pend_target;
    misaligned_n      = 1'b0;
    misaligned_addr_n = misaligned_addr;
    unique case (state)
      BOOT: begin
        state_n = RUN;
      end
      RUN: begin
        if (halt_req) begin
          state_n       = HALTED;
          pend_target_n = '0;
        end else if (advance) begin
          pc_n = redirect ? resolved_target : pc + STEP_W;
          misaligned_n = raw_misaligned;
        end else if (redirect) begin
          pend_target_n = resolved_target;
          state_n       = HOLD;
          misaligned_n  = raw_misaligned;
        end
      end
      HOLD: begin
        if (halt_req) begin
          state_n       = HALTED;
          pend_target_n = '0;
        end else if (advance) begin
          pc_n          = redirect ? resolved_target : pend_target;
          pend_target_n = '0;
          state_n       = RUN;
          misaligned_n  = raw_misaligned;
        end else if (redirect) begin
          // newest redirect replaces the parked one
          pend_target_n = resolved_target;
          misaligned_n  = raw_misaligned;
        end
      end
      HALTED: begin
        if (TrapReq) begin
          pc_n    = TRAP_VECTOR;
          state_n = RUN;
        end
      end
      default: state_n = BOOT;
    endcase
    if (misaligned_n)
      misaligned_addr_n = raw_target;
  end

  // Status outputs decoded from state
  always_comb begin
    pc_valid = (state == RUN) || (state == HOLD);
    pending  = (state == HOLD);
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vectors for pc_gen with hand-computed expectations.
module tb_pc_gen;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Enable, Stall, FetchReady;
  logic        BranchTaken, JumpAbs, TrapReq, Halt;
  logic [31:0] BranchOffset, JumpTarget;
  logic [31:0] pc, misaligned_addr;
  logic        pc_valid, pending, misaligned;

  int n_cmp = 0;
  int n_err = 0;

  pc_gen dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Stall(Stall),
    .FetchReady(FetchReady), .BranchTaken(BranchTaken),
    .BranchOffset(BranchOffset), .JumpAbs(JumpAbs), .JumpTarget(JumpTarget),
    .TrapReq(TrapReq), .Halt(Halt), .pc(pc), .pc_valid(pc_valid),
    .pending(pending), .misaligned(misaligned),
    .misaligned_addr(misaligned_addr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance one clock edge, then settle before checking
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] epc, input logic evalid,
                         input logic epend, input logic emis);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".valid"}, {31'd0, pc_valid}, {31'd0, evalid});
    chk({tag, ".pending"}, {31'd0, pending}, {31'd0, epend});
    chk({tag, ".mis"}, {31'd0, misaligned}, {31'd0, emis});
  endtask

  initial begin
    Reset = 1'b1; Enable = 1'b1; Stall = 1'b0; FetchReady = 1'b1;
    BranchTaken = 1'b0; JumpAbs = 1'b0; TrapReq = 1'b0; Halt = 1'b0;
    BranchOffset = '0; JumpTarget = '0;

    repeat (2) @(posedge Clk);
    #1;
    chk_all("rst", 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst.maddr", misaligned_addr, 32'h0);
    Reset = 1'b0;

    // boot then sequential fetch
    chk_all("boot", 32'h0, 1'b0, 1'b0, 1'b0);
    step(); chk_all("run0", 32'h0, 1'b1, 1'b0, 1'b0);
    step(); chk_all("run4", 32'h4, 1'b1, 1'b0, 1'b0);
    step(); chk_all("run8", 32'h8, 1'b1, 1'b0, 1'b0);

    // absolute jump to 0x100, then relative branches
    JumpAbs = 1'b1; JumpTarget = 32'h100;
    step(); chk_all("jmp100", 32'h100, 1'b1, 1'b0, 1'b0);
    JumpAbs = 1'b0; BranchTaken = 1'b1; BranchOffset = 32'hFFFF_FFF8;
    step(); chk_all("br-8", 32'hF8, 1'b1, 1'b0, 1'b0);
    BranchOffset = 32'h8;
    step(); chk_all("br+8", 32'h100, 1'b1, 1'b0, 1'b0);
    BranchOffset = 32'h6;
    step(); chk_all("brmis", 32'h100, 1'b1, 1'b0, 1'b1);
    chk("brmis.maddr", misaligned_addr, 32'h106);
    BranchTaken = 1'b0;
    step(); chk_all("afterm", 32'h104, 1'b1, 1'b0, 1'b0);
    chk("afterm.maddr", misaligned_addr, 32'h106);

    // stalled jump parks, newer branch overwrites, released on advance
    Stall = 1'b1; JumpAbs = 1'b1; JumpTarget = 32'h2001;
    step(); chk_all("hold1", 32'h104, 1'b1, 1'b1, 1'b0);
    JumpAbs = 1'b0; BranchTaken = 1'b1; BranchOffset = 32'h10;
    step(); chk_all("hold2", 32'h104, 1'b1, 1'b1, 1'b0);
    BranchTaken = 1'b0; Stall = 1'b0;
    step(); chk_all("release", 32'h114, 1'b1, 1'b0, 1'b0);

    // stalled with no redirect: pc held in RUN
    Stall = 1'b1;
    step(); chk_all("stall", 32'h114, 1'b1, 1'b0, 1'b0);
    Stall = 1'b0;

    // trap beats jump and halt
    TrapReq = 1'b1; JumpAbs = 1'b1; JumpTarget = 32'h2000; Halt = 1'b1;
    step(); chk_all("trapwin", 32'h100, 1'b1, 1'b0, 1'b0);
    TrapReq = 1'b0; JumpAbs = 1'b0; Halt = 1'b0;
    step(); chk_all("postrap", 32'h104, 1'b1, 1'b0, 1'b0);

    // halt freezes pc; jumps ignored while halted; trap restarts
    Halt = 1'b1;
    step(); chk_all("halt", 32'h104, 1'b0, 1'b0, 1'b0);
    Halt = 1'b0; JumpAbs = 1'b1; JumpTarget = 32'h3000;
    for (int i = 0; i < 5; i++) begin
      step(); chk_all("halted", 32'h104, 1'b0, 1'b0, 1'b0);
    end
    JumpAbs = 1'b0; TrapReq = 1'b1;
    step(); chk_all("unhalt", 32'h100, 1'b1, 1'b0, 1'b0);
    TrapReq = 1'b0;

    // wrap-around of sequential advance
    JumpAbs = 1'b1; JumpTarget = 32'hFFFF_FFFC;
    step(); chk_all("top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    JumpAbs = 1'b0;
    step(); chk_all("wrap", 32'h0, 1'b1, 1'b0, 1'b0);
    step(); chk_all("wrap4", 32'h4, 1'b1, 1'b0, 1'b0);

    // asynchronous reset while a redirect is parked
    Stall = 1'b1; BranchTaken = 1'b1; BranchOffset = 32'h20;
    step(); chk_all("prehold", 32'h4, 1'b1, 1'b1, 1'b0);
    BranchTaken = 1'b0; Stall = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk_all("arst", 32'h0, 1'b0, 1'b0, 1'b0);
    chk("arst.maddr", misaligned_addr, 32'h0);
    #1 Reset = 1'b0;
    step(); chk_all("rerun0", 32'h0, 1'b1, 1'b0, 1'b0);
    step(); chk_all("rerun4", 32'h4, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
